// File: rtl/lsq_mem_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsq_mem_issue_pkg
// Purpose  : Shared LSQ entry layout, error codes and issue-FSM states.
// Revision : 1.0
// ============================================================================
package lsq_mem_issue_pkg;

    localparam int LSQ_PC_W    = 12;
    localparam int LSQ_ADDR_W  = 32;
    localparam int LSQ_DATA_W  = 32;

    // Entry layout {is_load, pc, addr, data}, is_load in the MSB
    localparam int DATA_LSB    = 0;
    localparam int ADDR_LSB    = DATA_LSB + LSQ_DATA_W;
    localparam int PC_LSB      = ADDR_LSB + LSQ_ADDR_W;
    localparam int IS_LOAD_BIT = PC_LSB + LSQ_PC_W;
    localparam int LSQ_ENTRY   = IS_LOAD_BIT + 1;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/lsq_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : lsq_timeout_ctr
// Purpose  : Clearable wait counter; expire_o asserts at TIMEOUT-1 and holds.
// Revision : 1.0
// ============================================================================
module lsq_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expire_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/lsq_mem_issue.sv
`default_nettype none
// ============================================================================
// Module   : lsq_mem_issue
// Purpose  : Pops the LSQ head, issues it to data memory, returns load data.
// Revision : 1.0
// ============================================================================
module lsq_mem_issue
    import lsq_mem_issue_pkg::*;
#(
    parameter int PC_WIDTH   = LSQ_PC_W,
    parameter int ADDR_WIDTH = LSQ_ADDR_W,
    parameter int DATA_WIDTH = LSQ_DATA_W,
    parameter int TIMEOUT    = 64
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    ent_valid,
    input  logic [PC_WIDTH+ADDR_WIDTH+DATA_WIDTH:0] ent_data,
    output logic                                    ent_pop,
    input  logic                                    store_commit_ok,
    output logic                                    mem_req_valid,
    input  logic                                    mem_req_ready,
    output logic                                    mem_req_we,
    output logic [ADDR_WIDTH-1:0]                   mem_req_addr,
    output logic [DATA_WIDTH-1:0]                   mem_req_wdata,
    input  logic                                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]                   mem_resp_rdata,
    output logic                                    wb_valid,
    input  logic                                    wb_ready,
    output logic [PC_WIDTH-1:0]                     wb_pc,
    output logic [DATA_WIDTH-1:0]                   wb_data,
    output logic                                    err_valid,
    output logic [1:0]                              err_code,
    output logic [PC_WIDTH-1:0]                     err_pc,
    output logic                                    busy
);

    // Same field order as the shared layout, sized by this instance's widths
    localparam int E_ADDR_LSB = DATA_WIDTH;
    localparam int E_PC_LSB   = E_ADDR_LSB + ADDR_WIDTH;
    localparam int E_LOAD_BIT = E_PC_LSB + PC_WIDTH;

    state_e                state_q;
    logic                  we_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  req_valid_q;
    logic                  wb_valid_q;
    logic                  err_valid_q;
    logic [1:0]            err_code_q;
    logic [PC_WIDTH-1:0]   err_pc_q;
    logic                  busy_q;

    logic                  w_is_load;
    logic [PC_WIDTH-1:0]   w_pc;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_capture;
    logic                  w_misalign;
    logic                  w_expire;

    assign w_is_load  = ent_data[E_LOAD_BIT];
    assign w_pc       = ent_data[E_PC_LSB +: PC_WIDTH];
    assign w_addr     = ent_data[E_ADDR_LSB +: ADDR_WIDTH];
    assign w_data     = ent_data[0 +: DATA_WIDTH];
    assign w_misalign = (w_addr[1:0] != 2'b00);

    // Pop is combinational so the LSQ sees it in the capture cycle
    assign w_capture  = !rst && (state_q == ST_IDLE) && ent_valid
                        && (w_is_load || store_commit_ok);

    lsq_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == ST_REQ),
        .en_i     ((state_q == ST_RESP) && !mem_resp_valid),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            pc_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            req_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_pc_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_pc_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (w_capture) begin
                        we_q    <= !w_is_load;
                        pc_q    <= w_pc;
                        addr_q  <= w_addr;
                        wdata_q <= w_data;
                        if (w_misalign) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_MISALIGN;
                            err_pc_q    <= w_pc;
                        end else begin
                            state_q     <= ST_REQ;
                            req_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        if (we_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    // A response on the last counted cycle still wins over timeout
                    if (mem_resp_valid) begin
                        rdata_q    <= mem_resp_rdata;
                        wb_valid_q <= 1'b1;
                        state_q    <= ST_WB;
                    end else if (w_expire) begin
                        err_valid_q <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                        err_pc_q    <= pc_q;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ent_pop       = w_capture;
    assign mem_req_valid = req_valid_q;
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_pc         = pc_q;
    assign wb_data       = rdata_q;
    assign err_valid     = err_valid_q;
    assign err_code      = err_code_q;
    assign err_pc        = err_pc_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lsq_mem_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsq_mem_issue
// Purpose  : Directed and randomized checks of lsq_mem_issue vs an event model.
// Revision : 1.0
// ============================================================================
module tb_lsq_mem_issue;

    localparam int PCW = 12;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 8;
    localparam int EW  = 1 + PCW + AW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ent_valid = 1'b0;
    logic [EW-1:0] ent_data = '0;
    logic          ent_pop;
    logic          store_commit_ok = 1'b0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_resp_rdata = '0;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic [PCW-1:0] wb_pc;
    logic [DW-1:0] wb_data;
    logic          err_valid;
    logic [1:0]    err_code;
    logic [PCW-1:0] err_pc;
    logic          busy;

    int errors = 0;
    int checks = 0;

    lsq_mem_issue #(
        .PC_WIDTH   (PCW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ent_valid       (ent_valid),
        .ent_data        (ent_data),
        .ent_pop         (ent_pop),
        .store_commit_ok (store_commit_ok),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_we      (mem_req_we),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_rdata  (mem_resp_rdata),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_pc           (wb_pc),
        .wb_data         (wb_data),
        .err_valid       (err_valid),
        .err_code        (err_code),
        .err_pc          (err_pc),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Expected externally visible events: 0=request, 1=writeback, 2=error
    typedef struct {
        int          kind;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
    } evt_t;

    evt_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] mk(input logic ld, input logic [PCW-1:0] pc,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {ld, pc, a, d};
    endfunction

    task automatic quiet;
        ent_valid       = 1'b0;
        ent_data        = '0;
        store_commit_ok = 1'b0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        wb_ready        = 1'b0;
    endtask

    task automatic push_exp(input int k, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c);
        evt_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c);
        evt_t e;
        if (exp_q.size() == 0) begin
            chk("evt_unexpected", 64'(k), 64'd99);
        end else begin
            e = exp_q.pop_front();
            chk("evt_kind", 64'(k), 64'(e.kind));
            if (k == e.kind) begin
                chk("evt_a", a, e.a);
                chk("evt_b", b, e.b);
                if (k == 0 && a == 64'd1) chk("evt_wdata", c, e.c);
            end
        end
    endtask

    logic [EW-1:0] src_q[$];
    logic [EW-1:0] ent;
    logic [PCW-1:0] cur_pc;
    logic [AW-1:0]  ra;
    logic [DW-1:0]  resp_data;
    int             resp_at;
    int             d;
    bit             exp_pop;
    bit             done;

    initial begin
        // ---------------- reset state (pop must stay low while in reset)
        quiet();
        rst       = 1'b1;
        ent_valid = 1'b1;
        ent_data  = mk(1'b1, 12'h001, 32'h10, 32'h0);
        tick(); tick();
        chk("rst_pop", ent_pop, 0);
        chk("rst_req", mem_req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wb", wb_valid, 0);
        chk("rst_err", err_valid, 0);
        chk("rst_addr", mem_req_addr, 0);
        quiet();
        rst = 1'b0;
        tick();

        // ---------------- load happy path
        ent_valid = 1'b1; ent_data = mk(1'b1, 12'h010, 32'h40, 32'h0); mem_req_ready = 1'b1;
        #1 chk("ld_pop", ent_pop, 1);
        tick(); ent_valid = 1'b0;
        chk("ld_req", mem_req_valid, 1);
        chk("ld_we", mem_req_we, 0);
        chk("ld_addr", mem_req_addr, 32'h40);
        chk("ld_busy", busy, 1);
        tick();
        chk("ld_req_done", mem_req_valid, 0);
        tick();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEADBEEF;
        chk("ld_wb_early", wb_valid, 0);
        tick(); mem_resp_valid = 1'b0; wb_ready = 1'b1;
        chk("ld_wb", wb_valid, 1);
        chk("ld_wb_pc", wb_pc, 12'h010);
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        tick();
        chk("ld_idle", busy, 0);
        quiet();

        // ---------------- store gating
        ent_valid = 1'b1; ent_data = mk(1'b0, 12'h020, 32'h80, 32'h12345678); mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("st_gated_pop", ent_pop, 0);
            tick();
            chk("st_gated_req", mem_req_valid, 0);
        end
        store_commit_ok = 1'b1;
        #1 chk("st_pop", ent_pop, 1);
        tick(); ent_valid = 1'b0; store_commit_ok = 1'b0;
        chk("st_req", mem_req_valid, 1);
        chk("st_we", mem_req_we, 1);
        chk("st_addr", mem_req_addr, 32'h80);
        chk("st_wdata", mem_req_wdata, 32'h12345678);
        tick();
        chk("st_idle", busy, 0);
        chk("st_one_req", mem_req_valid, 0);
        chk("st_no_wb", wb_valid, 0);
        quiet();

        // ---------------- backpressure on request and writeback
        ent_valid = 1'b1; ent_data = mk(1'b1, 12'h055, 32'h100, 32'h0);
        tick(); ent_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_req", mem_req_valid, 1);
            chk("bp_addr", mem_req_addr, 32'h100);
            chk("bp_we", mem_req_we, 0);
            tick();
        end
        mem_req_ready = 1'b1;
        chk("bp_req_hs", mem_req_valid, 1);
        tick(); mem_req_ready = 1'b0;
        chk("bp_req_once", mem_req_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFEF00D;
        tick(); mem_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_wb", wb_valid, 1);
            chk("bp_wb_pc", wb_pc, 12'h055);
            chk("bp_wb_data", wb_data, 32'hCAFEF00D);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        chk("bp_wb_once", wb_valid, 0);
        chk("bp_idle", busy, 0);
        quiet();

        // ---------------- misaligned load
        ent_valid = 1'b1; ent_data = mk(1'b1, 12'h030, 32'h42, 32'h0); mem_req_ready = 1'b1;
        #1 chk("mis_pop", ent_pop, 1);
        tick(); ent_valid = 1'b0;
        chk("mis_no_req", mem_req_valid, 0);
        chk("mis_err", err_valid, 1);
        chk("mis_code", err_code, 2'b01);
        chk("mis_pc", err_pc, 12'h030);
        chk("mis_busy", busy, 0);
        tick();
        chk("mis_err_pulse", err_valid, 0);
        chk("mis_no_req2", mem_req_valid, 0);
        quiet();

        // ---------------- timeout, then a late response
        ent_valid = 1'b1; ent_data = mk(1'b1, 12'h077, 32'h200, 32'h0); mem_req_ready = 1'b1;
        tick(); ent_valid = 1'b0;
        tick(); mem_req_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("to_wait_err", err_valid, 0);
            chk("to_wait_busy", busy, 1);
            tick();
        end
        chk("to_err", err_valid, 1);
        chk("to_code", err_code, 2'b10);
        chk("to_pc", err_pc, 12'h077);
        chk("to_idle", busy, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555AAAA;
        tick(); mem_resp_valid = 1'b0;
        chk("to_late_wb", wb_valid, 0);
        chk("to_err_pulse", err_valid, 0);
        quiet();

        // ---------------- reset while waiting for a response
        ent_valid = 1'b1; ent_data = mk(1'b1, 12'h0AA, 32'h300, 32'h0); mem_req_ready = 1'b1;
        tick(); ent_valid = 1'b0;
        tick(); mem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rr_busy", busy, 0);
        chk("rr_req", mem_req_valid, 0);
        chk("rr_wb", wb_valid, 0);
        chk("rr_err", err_valid, 0);
        chk("rr_addr", mem_req_addr, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0BAD0BAD;
        tick(); mem_resp_valid = 1'b0;
        chk("rr_late_wb", wb_valid, 0);
        chk("rr_late_busy", busy, 0);
        ent_valid = 1'b1; ent_data = mk(1'b1, 12'h0BB, 32'h400, 32'h0); mem_req_ready = 1'b1;
        tick(); ent_valid = 1'b0;
        chk("rr_next_addr", mem_req_addr, 32'h400);
        tick();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h00001234;
        tick(); mem_resp_valid = 1'b0; wb_ready = 1'b1;
        chk("rr_next_wb", wb_valid, 1);
        chk("rr_next_pc", wb_pc, 12'h0BB);
        chk("rr_next_data", wb_data, 32'h00001234);
        tick();
        quiet();
        tick();

        // ---------------- randomized traffic against the event model
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            src_q.push_back(mk(1'($urandom_range(0, 1)), PCW'($urandom), ra, $urandom));
        end
        resp_at = -1;
        cur_pc  = '0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            ent_valid       = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
            ent_data        = (src_q.size() > 0) ? src_q[0] : '0;
            store_commit_ok = 1'($urandom_range(0, 1));
            mem_req_ready   = 1'($urandom_range(0, 1));
            wb_ready        = 1'($urandom_range(0, 1));
            // Stray responses while idle must be ignored
            mem_resp_valid  = (cyc == resp_at) || (!busy && $urandom_range(0, 7) == 0);
            mem_resp_rdata  = (cyc == resp_at) ? resp_data : DW'($urandom);
            #1;
            exp_pop = !busy && ent_valid && (ent_data[EW-1] || store_commit_ok);
            chk("rnd_pop", ent_pop, exp_pop);
            if (ent_pop) begin
                ent    = src_q.pop_front();
                cur_pc = ent[EW-2 -: PCW];
                ra     = ent[DW +: AW];
                if (ra[1:0] != 2'b00)
                    push_exp(2, 64'd1, 64'(cur_pc), 64'd0);
                else
                    push_exp(0, 64'(!ent[EW-1]), 64'(ra), 64'(ent[DW-1:0]));
            end
            if (mem_req_valid && mem_req_ready) begin
                observe(0, 64'(mem_req_we), 64'(mem_req_addr), 64'(mem_req_wdata));
                if (!mem_req_we) begin
                    d         = $urandom_range(1, TO + 2);
                    resp_at   = cyc + d;
                    resp_data = $urandom;
                    if (d <= TO) push_exp(1, 64'(cur_pc), 64'(resp_data), 64'd0);
                    else         push_exp(2, 64'd2, 64'(cur_pc), 64'd0);
                end
            end
            if (wb_valid && wb_ready) observe(1, 64'(wb_pc), 64'(wb_data), 64'd0);
            if (err_valid)            observe(2, 64'(err_code), 64'(err_pc), 64'd0);
            done = (src_q.size() == 0) && (exp_q.size() == 0) && !busy && (resp_at < cyc);
            tick();
        end
        chk("rnd_drained", 64'(done), 64'd1);
        quiet();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
